// File: rtl/adder_pkg.sv
// Shared definitions for the serial carry-skip subtractor: FSM states,
// default geometry and the block-count helper.
package adder_pkg;

  localparam int WIDTH = 18;
  localparam int BLK   = 3;

  function automatic int nblk(input int width, input int blk);
    return width / blk;
  endfunction

  localparam int NBLK  = nblk(WIDTH, BLK);
  localparam int IDX_W = $clog2(NBLK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/skip_sub_block.sv
// One BLK-bit carry-skip slice: ripple sum of a + b + cin, with the skip
// path flagging an all-propagate block fed by an incoming carry.
module skip_sub_block
  import adder_pkg::*;
#(
  parameter int BLK = adder_pkg::BLK
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           co,
  output logic           skip
);

  logic [BLK:0]   c;
  logic [BLK-1:0] p;

  // Ripple through the slice; carry-out also takes the skip path.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    p    = a ^ b;
    for (int i = 0; i < BLK; i++) begin
      s[i]   = p[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
    skip = (&p) & cin;
    co   = c[BLK] | skip;
  end

endmodule

// File: rtl/block_serial_skip_subtractor.sv
// Serial D = X - Y: one carry-skip block per clock, LSB block first, wrapped
// in a valid/ready handshake with no overlap between operations.
module block_serial_skip_subtractor
  import adder_pkg::*;
#(
  parameter int WIDTH = adder_pkg::WIDTH,
  parameter int BLK   = adder_pkg::BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   D,
  output logic [2:0]       skip_count
);

  localparam int NB = nblk(WIDTH, BLK);
  localparam int IW = $clog2(NB);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] yn_q, yn_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH:0]   d_q, d_d;
  logic [2:0]       skip_q, skip_d;

  logic [BLK-1:0]   blk_x, blk_yn, blk_s;
  logic             blk_co, blk_skip;
  logic             last_blk, accept;

  assign blk_x    = x_q[idx_q*BLK +: BLK];
  assign blk_yn   = yn_q[idx_q*BLK +: BLK];
  assign last_blk = (idx_q == IW'(NB - 1));
  assign accept   = (state_q == IDLE) && in_valid;

  skip_sub_block #(.BLK(BLK)) u_blk (
    .a    (blk_x),
    .b    (blk_yn),
    .cin  (carry_q),
    .s    (blk_s),
    .co   (blk_co),
    .skip (blk_skip)
  );

  // State and datapath registers; rst wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      yn_q    <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      d_q     <= '0;
      skip_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      yn_q    <= yn_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY; else state_d = IDLE;
      BUSY:    if (last_blk)  state_d = DONE; else state_d = BUSY;
      DONE:    if (out_ready) state_d = IDLE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latch on accept, one block of result per BUSY cycle.
  always_comb begin
    x_d     = x_q;
    yn_d    = yn_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    d_d     = d_q;
    skip_d  = skip_q;
    if (accept) begin
      x_d     = X;
      yn_d    = ~Y;
      carry_d = 1'b1;
      idx_d   = '0;
      d_d     = '0;
      skip_d  = 3'd0;
    end else if (state_q == BUSY) begin
      d_d[idx_q*BLK +: BLK] = blk_s;
      carry_d = blk_co;
      idx_d   = idx_q + 1'b1;
      if (blk_skip && (skip_q != 3'd7)) skip_d = skip_q + 3'd1;
      else                               skip_d = skip_q;
      // Final carry-out of X + ~Y + 1 is the inverted borrow.
      if (last_blk) d_d[WIDTH] = ~blk_co;
      else          d_d[WIDTH] = d_q[WIDTH];
    end else begin
      idx_d = idx_q;
    end
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
  end

  assign D          = d_q;
  assign skip_count = skip_q;

endmodule

// File: tb/tb_block_serial_skip_subtractor.sv
// Directed and random checks of the serial subtractor against a queue of
// expected differences computed from {0,X} - {0,Y}.
module tb_block_serial_skip_subtractor;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] X = '0;
  logic [W-1:0] Y = '0;
  logic         in_ready, out_valid;
  logic [W:0]   D;
  logic [2:0]   skip_count;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int results = 0;
  int aborted = 0;
  logic [W:0] sb[$];

  block_serial_skip_subtractor dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .X          (X),
    .Y          (Y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .D          (D),
    .skip_count (skip_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe handshakes mid-cycle, then advance to just after the next edge.
  task automatic step();
    logic [W:0] e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      results++;
      if (sb.size() == 0) begin
        check("result_without_accept", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("scoreboard_D", 32'(D), 32'(e));
      end
    end
    if (!rst && in_valid && in_ready) begin
      sb.push_back({1'b0, X} - {1'b0, Y});
      accepts++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W:0] exp_d, input int exp_skip);
    int lat;
    out_ready = 1'b1;
    wait_ready();
    X = x;
    Y = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    X = W'($urandom);
    Y = W'($urandom);
    wait_out(lat);
    check({tag, "_latency"}, 32'(lat), 32'd6);
    check({tag, "_D"}, 32'(D), 32'(exp_d));
    if (exp_skip >= 0) check({tag, "_skip"}, 32'(skip_count), 32'(exp_skip));
    step();
  endtask

  initial begin
    int lat;
    int cyc;
    int target;
    logic [W:0] held;

    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_D", 32'(D), 32'd0);
    check("reset_skip", 32'(skip_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    run_op("sub_5_3", 18'd5, 18'd3, 19'h00002, 5);
    run_op("sub_0_1", 18'd0, 18'd1, 19'h7FFFF, 0);
    run_op("sub_max_0", 18'h3FFFF, 18'd0, 19'h3FFFF, 0);
    run_op("all_propagate", 18'h2AAAA, 18'h2AAAA, 19'h00000, 6);

    // Backpressure: result must sit untouched in DONE.
    out_ready = 1'b0;
    wait_ready();
    X = 18'h12345;
    Y = 18'h00321;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(lat);
    check("bp_D", 32'(D), 32'h12024);
    held = D;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_D_stable", 32'(D), 32'(held));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Reset after three blocks discards the partial result.
    wait_ready();
    X = 18'h001C7;
    Y = 18'h001C0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check("midbusy_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb.pop_back());
    aborted++;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_D", 32'(D), 32'd0);
    check("abort_skip", 32'(skip_count), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    run_op("sub_100_200", 18'd100, 18'd200, 19'h7FF9C, -1);

    // Random traffic with random valid/ready.
    target = accepts + 1000;
    cyc = 0;
    while (accepts < target && cyc < 40000) begin
      in_valid  = 1'($urandom_range(0, 1));
      X         = W'($urandom);
      Y         = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("random_accepts", 32'(accepts >= target), 32'd1);
    out_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 40) begin
      step();
      cyc++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("one_result_per_accept", 32'(results), 32'(accepts - aborted));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
